axi3_wr_arbiter: RTL and testbench

//  Round-robin arbiter on the AXI3 write path, directly downstream of the cache write buffers.

---
 rtl/axi3_wr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_axi3_wr_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi3_wr_arbiter
//
// Round-robin arbiter on the AXI3 write path, sitting directly downstream of
// the cache write buffers. Merges N_MASTERS upstream AXI3 write masters onto a
// single AXI3 write port. Exactly one transaction is in flight at a time; the
// grant is taken in IDLE and held from the AW handshake through the B
// handshake. A granted master whose wlast does not line up with awlen+1 beats
// sets a sticky error flag.
//
// Handshake semantics (all channels, both sides): a transfer happens on a
// rising clk edge where valid and ready are both 1. A source holds valid and
// its payload stable until that edge. This block never buffers a payload: the
// granted master's valid/payload go straight to m_*, and the downstream ready
// goes straight back to the granted master only. Everyone else sees ready=0
// (AW/W) or valid=0 (B).
//
// Ports (upstream buses are flat, master i occupies slice i):
//   clk, rst                 clock; synchronous active-high reset
//   i_s_aw*/o_s_awready      upstream write-address channels
//   i_s_w*/o_s_wready        upstream write-data channels
//   o_s_b*/i_s_bready        upstream write-response channels
//   o_m_aw*/i_m_awready      downstream write-address channel
//   o_m_w*/i_m_wready        downstream write-data channel
//   i_m_b*/o_m_bready        downstream write-response channel
//   o_grant_vld              a transaction currently owns the m_* port
//   o_grant_idx              index of the owning master (valid with grant_vld)
//   o_err_wlast              sticky: wlast position disagreed with awlen
//   o_dbg_state              FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP)
//   o_dbg_beat_cnt           W beats accepted in the current burst
// ---------------------------------------------------------------------------
module axi3_wr_arbiter #(
   parameter int N_MASTERS  = 2,
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
   localparam int STRB_W    = DATA_WIDTH / 8
) (
   input  logic                            clk,
   input  logic                            rst,

   // upstream AW
   input  logic [N_MASTERS-1:0]            i_s_awvalid,
   output logic [N_MASTERS-1:0]            o_s_awready,
   input  logic [N_MASTERS*ID_WIDTH-1:0]   i_s_awid,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0] i_s_awaddr,
   input  logic [N_MASTERS*4-1:0]          i_s_awlen,
   input  logic [N_MASTERS*3-1:0]          i_s_awsize,
   input  logic [N_MASTERS*2-1:0]          i_s_awburst,

   // upstream W
   input  logic [N_MASTERS-1:0]            i_s_wvalid,
   output logic [N_MASTERS-1:0]            o_s_wready,
   input  logic [N_MASTERS*ID_WIDTH-1:0]   i_s_wid,
   input  logic [N_MASTERS*DATA_WIDTH-1:0] i_s_wdata,
   input  logic [N_MASTERS*STRB_W-1:0]     i_s_wstrb,
   input  logic [N_MASTERS-1:0]            i_s_wlast,

   // upstream B
   output logic [N_MASTERS-1:0]            o_s_bvalid,
   input  logic [N_MASTERS-1:0]            i_s_bready,
   output logic [N_MASTERS*ID_WIDTH-1:0]   o_s_bid,
   output logic [N_MASTERS*2-1:0]          o_s_bresp,

   // downstream AW
   output logic                            o_m_awvalid,
   input  logic                            i_m_awready,
   output logic [ID_WIDTH-1:0]             o_m_awid,
   output logic [ADDR_WIDTH-1:0]           o_m_awaddr,
   output logic [3:0]                      o_m_awlen,
   output logic [2:0]                      o_m_awsize,
   output logic [1:0]                      o_m_awburst,

   // downstream W
   output logic                            o_m_wvalid,
   input  logic                            i_m_wready,
   output logic [ID_WIDTH-1:0]             o_m_wid,
   output logic [DATA_WIDTH-1:0]           o_m_wdata,
   output logic [STRB_W-1:0]               o_m_wstrb,
   output logic                            o_m_wlast,

   // downstream B
   input  logic                            i_m_bvalid,
   output logic                            o_m_bready,
   input  logic [ID_WIDTH-1:0]             i_m_bid,
   input  logic [1:0]                      i_m_bresp,

   // status / debug
   output logic                            o_grant_vld,
   output logic [IDX_W-1:0]                o_grant_idx,
   output logic                            o_err_wlast,
   output logic [1:0]                      o_dbg_state,
   output logic [3:0]                      o_dbg_beat_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [IDX_W-1:0]  r_sel;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic              r_grant_vld;
   logic              r_err_wlast;
   logic [3:0]        r_len;
   logic [3:0]        r_beat_cnt;

   // granted master's channel signals
   logic                  w_sel_awvalid;
   logic [ID_WIDTH-1:0]   w_sel_awid;
   logic [ADDR_WIDTH-1:0] w_sel_awaddr;
   logic [3:0]            w_sel_awlen;
   logic [2:0]            w_sel_awsize;
   logic [1:0]            w_sel_awburst;
   logic                  w_sel_wvalid;
   logic [ID_WIDTH-1:0]   w_sel_wid;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic [STRB_W-1:0]     w_sel_wstrb;
   logic                  w_sel_wlast;
   logic                  w_sel_bready;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_found;
   logic [IDX_W-1:0]      w_pick;
   logic [IDX_W-1:0]      w_cand;
   logic [IDX_W:0]        w_sum;
   logic [IDX_W-1:0]      w_rr_nxt;

   // ------------------------------------------------------------------
   // Mux of the granted master (r_sel is registered, so these are
   // stable for the whole transaction).
   // ------------------------------------------------------------------
   assign w_sel_awvalid = i_s_awvalid[r_sel];
   assign w_sel_awid    = i_s_awid   [r_sel*ID_WIDTH   +: ID_WIDTH];
   assign w_sel_awaddr  = i_s_awaddr [r_sel*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel_awlen   = i_s_awlen  [r_sel*4          +: 4];
   assign w_sel_awsize  = i_s_awsize [r_sel*3          +: 3];
   assign w_sel_awburst = i_s_awburst[r_sel*2          +: 2];
   assign w_sel_wvalid  = i_s_wvalid [r_sel];
   assign w_sel_wid     = i_s_wid    [r_sel*ID_WIDTH   +: ID_WIDTH];
   assign w_sel_wdata   = i_s_wdata  [r_sel*DATA_WIDTH +: DATA_WIDTH];
   assign w_sel_wstrb   = i_s_wstrb  [r_sel*STRB_W     +: STRB_W];
   assign w_sel_wlast   = i_s_wlast  [r_sel];
   assign w_sel_bready  = i_s_bready [r_sel];

   // ------------------------------------------------------------------
   // Downstream port: valids gated by phase, payloads a plain mux.
   // ------------------------------------------------------------------
   assign o_m_awvalid = (r_state == ST_ADDR) && w_sel_awvalid;
   assign o_m_awid    = w_sel_awid;
   assign o_m_awaddr  = w_sel_awaddr;
   assign o_m_awlen   = w_sel_awlen;
   assign o_m_awsize  = w_sel_awsize;
   assign o_m_awburst = w_sel_awburst;

   assign o_m_wvalid  = (r_state == ST_DATA) && w_sel_wvalid;
   assign o_m_wid     = w_sel_wid;
   assign o_m_wdata   = w_sel_wdata;
   assign o_m_wstrb   = w_sel_wstrb;
   assign o_m_wlast   = w_sel_wlast;

   assign o_m_bready  = (r_state == ST_RESP) && w_sel_bready;

   // Response payload is broadcast; only the granted master sees bvalid.
   assign o_s_bid     = {N_MASTERS{i_m_bid}};
   assign o_s_bresp   = {N_MASTERS{i_m_bresp}};

   assign w_aw_hs = o_m_awvalid && i_m_awready;
   assign w_w_hs  = o_m_wvalid  && i_m_wready;
   assign w_b_hs  = i_m_bvalid  && o_m_bready;

   // ------------------------------------------------------------------
   // Upstream ready/valid returns: only the granted master, only in its
   // phase.
   // ------------------------------------------------------------------
   always_comb begin
      o_s_awready = '0;
      o_s_wready  = '0;
      o_s_bvalid  = '0;
      case (r_state)
         ST_ADDR: o_s_awready[r_sel] = i_m_awready;
         ST_DATA: o_s_wready[r_sel]  = i_m_wready;
         ST_RESP: o_s_bvalid[r_sel]  = i_m_bvalid;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Round-robin pick: first requester at or after r_rr_ptr, wrapping
   // modulo N_MASTERS. Candidates are walked in priority order and the
   // first hit wins.
   // ------------------------------------------------------------------
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      w_cand  = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(N_MASTERS)) begin
            w_sum = w_sum - (IDX_W+1)'(N_MASTERS);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (!w_found && i_s_awvalid[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   assign w_rr_nxt = (r_sel == IDX_W'(N_MASTERS-1)) ? '0 : r_sel + IDX_W'(1);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         // Selection only; no handshake can complete here, which gives the
         // one-cycle bubble before the AW phase.
         ST_IDLE: if (w_found) w_state_nxt = ST_ADDR;
         ST_ADDR: if (w_aw_hs) w_state_nxt = ST_DATA;
         // A missing wlast keeps us in DATA; the error flag reports it.
         ST_DATA: if (w_w_hs && w_sel_wlast) w_state_nxt = ST_RESP;
         ST_RESP: if (w_b_hs) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Grant, round-robin pointer, burst length check
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel       <= '0;
         r_rr_ptr    <= '0;
         r_grant_vld <= 1'b0;
         r_err_wlast <= 1'b0;
         r_len       <= '0;
         r_beat_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_sel       <= w_pick;
                  r_grant_vld <= 1'b1;
               end
            end
            ST_ADDR: begin
               // awlen is stable while awvalid waits for awready, so
               // sampling every ADDR cycle captures the handshake value.
               r_len      <= w_sel_awlen;
               r_beat_cnt <= '0;
            end
            ST_DATA: begin
               if (w_w_hs) begin
                  r_beat_cnt <= r_beat_cnt + 4'd1;
                  // r_beat_cnt counts beats before this one, so the legal
                  // last beat is the one where it equals awlen.
                  if (w_sel_wlast ? (r_beat_cnt != r_len)
                                  : (r_beat_cnt == r_len)) begin
                     r_err_wlast <= 1'b1;
                  end
               end
            end
            ST_RESP: begin
               if (w_b_hs) begin
                  r_rr_ptr    <= w_rr_nxt;
                  r_grant_vld <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_grant_vld    = r_grant_vld;
   assign o_grant_idx    = r_sel;
   assign o_err_wlast    = r_err_wlast;
   assign o_dbg_state    = r_state;
   assign o_dbg_beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi3_wr_arbiter
//
// Directed bench for axi3_wr_arbiter with two upstream masters. The bench
// plays both the upstream masters and the downstream slave. Inputs are driven
// just after the falling edge, outputs sampled 1 time unit later, so nothing
// is read at the active edge. W beats seen on m_* are checked in order
// against an expected queue filled by the driver.
// ---------------------------------------------------------------------------
module tb_axi3_wr_arbiter;

   localparam int N   = 2;
   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic clk = 1'b0;
   logic rst;

   logic [N-1:0]     s_awvalid, s_awready;
   logic [N*IDW-1:0] s_awid;
   logic [N*AW-1:0]  s_awaddr;
   logic [N*4-1:0]   s_awlen;
   logic [N*3-1:0]   s_awsize;
   logic [N*2-1:0]   s_awburst;
   logic [N-1:0]     s_wvalid, s_wready;
   logic [N*IDW-1:0] s_wid;
   logic [N*DW-1:0]  s_wdata;
   logic [N*4-1:0]   s_wstrb;
   logic [N-1:0]     s_wlast;
   logic [N-1:0]     s_bvalid, s_bready;
   logic [N*IDW-1:0] s_bid;
   logic [N*2-1:0]   s_bresp;

   logic            m_awvalid, m_awready;
   logic [IDW-1:0]  m_awid;
   logic [AW-1:0]   m_awaddr;
   logic [3:0]      m_awlen;
   logic [2:0]      m_awsize;
   logic [1:0]      m_awburst;
   logic            m_wvalid, m_wready;
   logic [IDW-1:0]  m_wid;
   logic [DW-1:0]   m_wdata;
   logic [3:0]      m_wstrb;
   logic            m_wlast;
   logic            m_bvalid, m_bready;
   logic [IDW-1:0]  m_bid;
   logic [1:0]      m_bresp;

   logic            grant_vld;
   logic [0:0]      grant_idx;
   logic            err_wlast;
   logic [1:0]      dbg_state;
   logic [3:0]      dbg_beat;

   int n_chk = 0;
   int n_bad = 0;
   int txn   = 0;
   logic [31:0] exp_q[$];

   axi3_wr_arbiter #(
      .N_MASTERS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst),
      .i_s_awvalid(s_awvalid), .o_s_awready(s_awready), .i_s_awid(s_awid),
      .i_s_awaddr(s_awaddr), .i_s_awlen(s_awlen), .i_s_awsize(s_awsize),
      .i_s_awburst(s_awburst),
      .i_s_wvalid(s_wvalid), .o_s_wready(s_wready), .i_s_wid(s_wid),
      .i_s_wdata(s_wdata), .i_s_wstrb(s_wstrb), .i_s_wlast(s_wlast),
      .o_s_bvalid(s_bvalid), .i_s_bready(s_bready), .o_s_bid(s_bid),
      .o_s_bresp(s_bresp),
      .o_m_awvalid(m_awvalid), .i_m_awready(m_awready), .o_m_awid(m_awid),
      .o_m_awaddr(m_awaddr), .o_m_awlen(m_awlen), .o_m_awsize(m_awsize),
      .o_m_awburst(m_awburst),
      .o_m_wvalid(m_wvalid), .i_m_wready(m_wready), .o_m_wid(m_wid),
      .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb), .o_m_wlast(m_wlast),
      .i_m_bvalid(m_bvalid), .o_m_bready(m_bready), .i_m_bid(m_bid),
      .i_m_bresp(m_bresp),
      .o_grant_vld(grant_vld), .o_grant_idx(grant_idx), .o_err_wlast(err_wlast),
      .o_dbg_state(dbg_state), .o_dbg_beat_cnt(dbg_beat)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: sample the W handshake about to happen, then move to the
   // next falling edge.
   task automatic tick();
      #1;
      if (m_wvalid && m_wready) begin
         if (exp_q.size() == 0) chk("w_unexpected_beat", 32'(exp_q.size()), 32'd1);
         else                   chk("wdata_order", m_wdata, exp_q.pop_front());
      end
      @(negedge clk);
   endtask

   // ---------------- drivers ----------------
   task automatic reset_dut();
      rst = 1'b1;
      s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
      m_bvalid = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic raise_aw(input int m, input logic [3:0] len);
      s_awvalid[m]          = 1'b1;
      s_awid[m*IDW +: IDW]  = 4'(m + 1);
      s_awaddr[m*AW +: AW]  = 32'h1000 * (m + 1);
      s_awlen[m*4 +: 4]     = len;
      s_awsize[m*3 +: 3]    = 3'd2;
      s_awburst[m*2 +: 2]   = 2'b01;
   endtask

   task automatic aw_wait(input int m, input logic [3:0] len);
      int cnt = 0;
      bit hs;
      logic [1:0] others;
      forever begin
         #1;
         others = s_awready;
         others[m] = 1'b0;
         chk("awready_other", 32'(others), 32'd0);
         hs = s_awready[m];
         if (hs) begin
            chk("grant_idx", 32'(grant_idx), 32'(m));
            chk("grant_vld", 32'(grant_vld), 32'd1);
            chk("m_awid", 32'(m_awid), 32'(m + 1));
            chk("m_awlen", 32'(m_awlen), 32'(len));
         end
         tick();
         if (hs) break;
         cnt++;
         if (cnt > 20) begin
            chk("aw_timeout", 32'(s_awready[m]), 32'd1);
            break;
         end
      end
      s_awvalid[m] = 1'b0;
   endtask

   task automatic w_phase(input int m, input int nb, input bit last, input bit toggle);
      int cyc = 0;
      int cnt;
      bit hs;
      logic [31:0] d;
      for (int b = 0; b < nb; b++) begin
         d = 32'hA000_0000 | (32'(m) << 16) | (32'(txn) << 8) | 32'(b);
         s_wvalid[m]         = 1'b1;
         s_wdata[m*DW +: DW] = d;
         s_wstrb[m*4 +: 4]   = 4'hF;
         s_wid[m*IDW +: IDW] = 4'(m + 1);
         s_wlast[m]          = last && (b == nb - 1);
         exp_q.push_back(d);
         cnt = 0;
         forever begin
            m_wready = toggle ? ((cyc % 2) == 0) : 1'b1;
            cyc++;
            #1;
            chk("wready_other", 32'(s_wready[1-m]), 32'd0);
            chk("awready_in_data", 32'(s_awready), 32'd0);
            hs = s_wready[m];
            tick();
            chk("beat_cnt", 32'(dbg_beat), hs ? 32'(b + 1) : 32'(b));
            if (hs) break;
            cnt++;
            if (cnt > 20) begin
               chk("w_timeout", 32'(s_wready[m]), 32'd1);
               break;
            end
         end
      end
      s_wvalid[m] = 1'b0;
      s_wlast[m]  = 1'b0;
      m_wready    = 1'b1;
      txn++;
   endtask

   task automatic b_phase(input int m, input int bhold);
      bit hs = 1'b0;
      m_bvalid = 1'b1;
      m_bid    = 4'(m + 1);
      m_bresp  = 2'b00;
      for (int k = 0; k < bhold + 20; k++) begin
         s_bready[m] = (k >= bhold);
         #1;
         chk("s_bvalid", 32'(s_bvalid[m]), 32'd1);
         chk("s_bvalid_other", 32'(s_bvalid[1-m]), 32'd0);
         if (k == 0) chk("s_bid", 32'(s_bid[m*IDW +: IDW]), 32'(m + 1));
         if (k < bhold) begin
            chk("bready_hold", 32'(m_bready), 32'd0);
            chk("grant_hold", 32'(grant_vld), 32'd1);
         end
         hs = m_bready;
         tick();
         if (hs) break;
      end
      if (!hs) chk("b_timeout", 32'(m_bready), 32'd1);
      m_bvalid    = 1'b0;
      s_bready[m] = 1'b0;
      #1;
      chk("b_done_state", 32'(dbg_state), 32'(S_IDLE));
      chk("b_done_grant", 32'(grant_vld), 32'd0);
      chk("s_bvalid_drop", 32'(s_bvalid[m]), 32'd0);
   endtask

   task automatic do_txn(input int m, input logic [3:0] len);
      raise_aw(m, len);
      aw_wait(m, len);
      w_phase(m, int'(len) + 1, 1'b1, 1'b0);
      b_phase(m, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0;
      s_awsize = '0; s_awburst = '0;
      s_wvalid = '0; s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
      s_bready = '0;
      m_awready = 1'b1; m_wready = 1'b1;
      m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
      repeat (3) @(negedge clk);

      // reset state (downstream readies high to show gating)
      #1;
      chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
      chk("rst_grant_vld", 32'(grant_vld), 32'd0);
      chk("rst_grant_idx", 32'(grant_idx), 32'd0);
      chk("rst_err", 32'(err_wlast), 32'd0);
      chk("rst_beat", 32'(dbg_beat), 32'd0);
      chk("rst_s_ready", 32'({s_awready, s_wready, s_bvalid}), 32'd0);
      chk("rst_m_valid", 32'({m_awvalid, m_wvalid, m_bready}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: single awlen=7 burst from s0
      raise_aw(0, 4'd7);
      #1;
      chk("idle_bubble_awready", 32'(s_awready[0]), 32'd0);
      chk("idle_bubble_state", 32'(dbg_state), 32'(S_IDLE));
      aw_wait(0, 4'd7);
      chk("t1_state_data", 32'(dbg_state), 32'(S_DATA));
      w_phase(0, 8, 1'b1, 1'b0);
      chk("t1_state_resp", 32'(dbg_state), 32'(S_RESP));
      chk("t1_err", 32'(err_wlast), 32'd0);
      b_phase(0, 0);
      chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

      // 2: simultaneous s0/s1 twice after reset -> s0 first both times
      reset_dut();
      for (int p = 0; p < 2; p++) begin
         raise_aw(0, 4'd3);
         raise_aw(1, 4'd3);
         aw_wait(0, 4'd3);
         w_phase(0, 4, 1'b1, 1'b0);
         b_phase(0, 0);
         aw_wait(1, 4'd3);
         w_phase(1, 4, 1'b1, 1'b0);
         b_phase(1, 0);
      end
      chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

      // 3: toggling wready; s1 waits with aw/w valid asserted
      raise_aw(0, 4'd7);
      aw_wait(0, 4'd7);
      raise_aw(1, 4'd1);
      s_wvalid[1]          = 1'b1;
      s_wdata[1*DW +: DW]  = 32'hBAD0_0001;
      w_phase(0, 8, 1'b1, 1'b1);
      s_wvalid[1] = 1'b0;
      b_phase(0, 0);
      aw_wait(1, 4'd1);
      w_phase(1, 2, 1'b1, 1'b0);
      b_phase(1, 0);
      chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

      // 4: s1 wlast on beat 4 of awlen=7
      raise_aw(1, 4'd7);
      aw_wait(1, 4'd7);
      w_phase(1, 4, 1'b1, 1'b0);
      chk("t4_state_resp", 32'(dbg_state), 32'(S_RESP));
      chk("t4_err_set", 32'(err_wlast), 32'd1);
      b_phase(1, 0);
      chk("t4_err_sticky", 32'(err_wlast), 32'd1);

      // 5: reset in DATA after 3 beats, then s1 serviced
      raise_aw(0, 4'd7);
      aw_wait(0, 4'd7);
      w_phase(0, 3, 1'b0, 1'b0);
      s_wvalid[0] = 1'b1;
      m_wready    = 1'b0;
      rst         = 1'b1;
      tick();
      #1;
      chk("t5_state", 32'(dbg_state), 32'(S_IDLE));
      chk("t5_grant_vld", 32'(grant_vld), 32'd0);
      chk("t5_err_clr", 32'(err_wlast), 32'd0);
      chk("t5_s_ready", 32'({s_awready, s_wready, s_bvalid}), 32'd0);
      chk("t5_m_valid", 32'({m_awvalid, m_wvalid, m_bready}), 32'd0);
      rst         = 1'b0;
      s_wvalid[0] = 1'b0;
      m_wready    = 1'b1;
      exp_q.delete();
      do_txn(1, 4'd3);
      chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

      // 6: s0 holds bready low for 5 cycles
      raise_aw(0, 4'd1);
      aw_wait(0, 4'd1);
      w_phase(0, 2, 1'b1, 1'b0);
      b_phase(0, 5);
      chk("t6_err", 32'(err_wlast), 32'd0);
      chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
